// File: rtl/ex_stage_md.sv
// MIPS execute stage: forwarding, ALU, branch target, EX/MEM register, iterative MUL/DIV with HI/LO (divider only with EX_DIV_EN).
// Latency: EX/MEM outputs one cycle after ID/EX; HI/LO valid WIDTH cycles after an MD op issues.
// Backpressure: stall_in freezes EX/MEM; ex_stall holds upstream while an MD op is in flight and a new md_op arrives.
module ex_stage_md #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5,
    parameter int CTRW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [CTRW-1:0]  ctrl_in,
    input  logic [3:0]       alu_op,
    input  logic [2:0]       md_op,
    input  logic             alu_src,
    input  logic             reg_dst,
    input  logic [WIDTH-1:0] pc_next,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] imm,
    input  logic [REGW-1:0]  rt_idx,
    input  logic [REGW-1:0]  rd_idx,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             stall_in,
    input  logic             flush,
    output logic             ex_stall,
    output logic             valid_out,
    output logic [CTRW-1:0]  ctrl_out,
    output logic [WIDTH-1:0] branch_target,
    output logic             zero,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] store_data,
    output logic [REGW-1:0]  dest_reg
);

    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;
`ifdef EX_DIV_EN
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
`endif
    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

    md_state_e          state_q;
    logic [CNTW-1:0]    cnt_q;
    logic [WIDTH-1:0]   acc_q, sh_q, dvs_q, hi_q, lo_q;
    logic               neg_lo_q;
`ifdef EX_DIV_EN
    logic               is_div_q, neg_hi_q;
`endif

    logic [WIDTH-1:0]   op_a, fwd_b_val, op_b, alu_res, ex_res;
    logic [WIDTH-1:0]   mag_a, mag_b, step_acc, step_sh, hi_d, lo_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic               md_mul, md_div, md_signed, md_start, sign_a, sign_b, md_neg_lo;

    always_comb begin
        op_a = rs_val;
        case (fwd_a)
            2'b01:   op_a = wb_result;
            2'b10:   op_a = mem_result;
            default: op_a = rs_val;
        endcase
        fwd_b_val = rt_val;
        case (fwd_b)
            2'b01:   fwd_b_val = wb_result;
            2'b10:   fwd_b_val = mem_result;
            default: fwd_b_val = rt_val;
        endcase
    end

    assign op_b = alu_src ? imm : fwd_b_val;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = op_a & op_b;
            4'd1:    alu_res = op_a | op_b;
            4'd2:    alu_res = op_a + op_b;
            4'd6:    alu_res = op_a - op_b;
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd12:   alu_res = ~(op_a | op_b);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ex_res = alu_res;
        if (md_op == MD_MFHI)      ex_res = hi_q;
        else if (md_op == MD_MFLO) ex_res = lo_q;
    end

    assign md_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
`ifdef EX_DIV_EN
    assign md_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign md_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
`else
    assign md_div    = 1'b0;
    assign md_signed = (md_op == MD_MULT);
`endif

    // md_op 7 is decoded as "no MD op" and never stalls.
    assign ex_stall = valid_in && (md_op != 3'd0) && (md_op != 3'd7) && (state_q != S_IDLE);
    assign md_start = valid_in && (md_mul || md_div) && !ex_stall && !stall_in;

    assign sign_a = md_signed & op_a[WIDTH-1];
    assign sign_b = md_signed & fwd_b_val[WIDTH-1];
    assign mag_a  = sign_a ? -op_a : op_a;
    assign mag_b  = sign_b ? -fwd_b_val : fwd_b_val;
`ifdef EX_DIV_EN
    // A zero divisor yields an all-ones quotient regardless of operand signs.
    assign md_neg_lo = (sign_a ^ sign_b) && !(md_div && (mag_b == '0));
`else
    assign md_neg_lo = sign_a ^ sign_b;
`endif

    assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});

`ifdef EX_DIV_EN
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_ge;

    assign div_shift = {acc_q, sh_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};
    assign div_ge    = !div_diff[WIDTH];

    always_comb begin
        step_acc = mul_sum[WIDTH:1];
        step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
        if (is_div_q) begin
            step_acc = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_sh  = {sh_q[WIDTH-2:0], div_ge};
        end
    end
`else
    assign step_acc = mul_sum[WIDTH:1];
    assign step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
`endif

    assign prod_mag = {step_acc, step_sh};
    assign prod_fix = neg_lo_q ? -prod_mag : prod_mag;

    always_comb begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`ifdef EX_DIV_EN
        if (is_div_q) begin
            lo_d = neg_lo_q ? -step_sh : step_sh;
            hi_d = neg_hi_q ? -step_acc : step_acc;
        end
`endif
    end

    // WIDTH iterations total: WIDTH-1 in BUSY, the last one folded into DONE with the HI/LO write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            dvs_q    <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef EX_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_start) begin
                        state_q  <= S_BUSY;
                        cnt_q    <= CNTW'(WIDTH-1);
                        acc_q    <= '0;
                        sh_q     <= mag_a;
                        dvs_q    <= mag_b;
                        neg_lo_q <= md_neg_lo;
`ifdef EX_DIV_EN
                        is_div_q <= md_div;
                        neg_hi_q <= sign_a;
`endif
                    end
                end
                S_BUSY: begin
                    acc_q <= step_acc;
                    sh_q  <= step_sh;
                    cnt_q <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) state_q <= S_DONE;
                end
                S_DONE: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out     <= 1'b0;
            ctrl_out      <= '0;
            branch_target <= '0;
            zero          <= 1'b0;
            alu_result    <= '0;
            store_data    <= '0;
            dest_reg      <= '0;
        end else if (!stall_in) begin
            valid_out     <= valid_in && !ex_stall && !flush;
            ctrl_out      <= ctrl_in;
            branch_target <= pc_next + (imm << 2);
            zero          <= (alu_res == '0);
            alu_result    <= ex_res;
            store_data    <= fwd_b_val;
            dest_reg      <= reg_dst ? rd_idx : rt_idx;
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md: reference model with HI/LO completion countdown plus directed literal checks.
module tb_ex_stage_md;

`ifdef EX_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in, alu_src, reg_dst, stall_in, flush;
    logic [4:0]  ctrl_in, rt_idx, rd_idx;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] pc_next, rs_val, rt_val, imm, mem_result, wb_result;
    logic        ex_stall, valid_out, zero;
    logic [4:0]  ctrl_out, dest_reg;
    logic [31:0] branch_target, alu_result, store_data;

    int checks = 0;
    int errors = 0;

    ex_stage_md dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ctrl_in(ctrl_in), .alu_op(alu_op),
        .md_op(md_op), .alu_src(alu_src), .reg_dst(reg_dst), .pc_next(pc_next),
        .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_result(mem_result), .wb_result(wb_result),
        .stall_in(stall_in), .flush(flush), .ex_stall(ex_stall), .valid_out(valid_out),
        .ctrl_out(ctrl_out), .branch_target(branch_target), .zero(zero),
        .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_valid = 1'b0, m_zero = 1'b0;
    logic [4:0]  m_ctrl = '0, m_dest = '0;
    logic [31:0] m_bt = '0, m_alu = '0, m_sd = '0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_cnt = 0;

    function automatic logic [31:0] fwd_sel(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'b01) return wb_result;
        if (s == 2'b10) return mem_result;
        return r;
    endfunction

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd6:    return x - y;
            4'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd12:   return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_stall();
        return valid_in && (md_op >= 3'd1) && (md_op <= 3'd6) && (m_cnt > 0);
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [31:0] a, b, r;
        logic [63:0] pr;
        longint      sa, sb;
        logic        st;
        if (!reset) begin
            m_valid = 0; m_zero = 0; m_ctrl = '0; m_dest = '0; m_bt = '0; m_alu = '0; m_sd = '0;
            m_hi = '0; m_lo = '0; m_cnt = 0;
        end else begin
            a  = fwd_sel(fwd_a, rs_val);
            b  = fwd_sel(fwd_b, rt_val);
            st = model_stall();
            if (!stall_in) begin
                r       = alu_f(alu_op, a, alu_src ? imm : b);
                m_valid = valid_in && !st && !flush;
                m_ctrl  = ctrl_in;
                m_bt    = pc_next + imm * 4;
                m_zero  = (r == 0);
                m_alu   = (md_op == 3'd5) ? m_hi : (md_op == 3'd6) ? m_lo : r;
                m_sd    = b;
                m_dest  = reg_dst ? rd_idx : rt_idx;
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
            end else if (valid_in && !st && !stall_in &&
                         (md_op == 3'd1 || md_op == 3'd2 || (DIV_EN && (md_op == 3'd3 || md_op == 3'd4)))) begin
                sa = $signed(a);
                sb = $signed(b);
                case (md_op)
                    3'd1: begin pr = sa * sb; p_hi = pr[63:32]; p_lo = pr[31:0]; end
                    3'd2: begin pr = {32'd0, a} * {32'd0, b}; p_hi = pr[63:32]; p_lo = pr[31:0]; end
                    3'd3: if (b == 0) begin p_lo = '1; p_hi = a; end
                          else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
                    default: if (b == 0) begin p_lo = '1; p_hi = a; end
                             else begin p_lo = a / b; p_hi = a % b; end
                endcase
                m_cnt = 32;
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_valid_out", 32'(valid_out), 32'(m_valid));
        check("cmp_ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
        check("cmp_branch_target", branch_target, m_bt);
        check("cmp_zero", 32'(zero), 32'(m_zero));
        check("cmp_alu_result", alu_result, m_alu);
        check("cmp_store_data", store_data, m_sd);
        check("cmp_dest_reg", 32'(dest_reg), 32'(m_dest));
        check("cmp_ex_stall", 32'(ex_stall), 32'(model_stall()));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        valid_in = 0; ctrl_in = '0; alu_op = 4'd2; md_op = 3'd0; alu_src = 0; reg_dst = 0;
        pc_next = '0; rs_val = '0; rt_val = '0; imm = '0; rt_idx = '0; rd_idx = '0;
        fwd_a = 2'b00; fwd_b = 2'b00; mem_result = '0; wb_result = '0; stall_in = 0; flush = 0;
    endtask

    task automatic instr(input logic [3:0] op, input logic [2:0] md, input logic [31:0] a, input logic [31:0] b);
        set_idle();
        valid_in = 1; alu_op = op; md_op = md; rs_val = a; rt_val = b;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        #1;
        while (ex_stall && n < 100) begin
            tick();
            n++;
        end
    endtask

    logic [3:0]  lop [5] = '{4'd0, 4'd1, 4'd12, 4'd7, 4'd5};
    logic [31:0] lexp[5] = '{32'h00F00000, 32'hFFF09235, 32'h000F6DCA, 32'h00000001, 32'h00000000};

    initial begin
        int n;
        set_idle();
        reset = 0;
        repeat (3) tick();
        check("reset_valid_out", 32'(valid_out), 0);
        check("reset_alu_result", alu_result, 0);
        check("reset_branch_target", branch_target, 0);
        check("reset_ex_stall", 32'(ex_stall), 0);
        reset = 1;

        instr(4'd2, 3'd6, 32'h0, 32'h0);                // MFLO after reset
        tick();
        check("mflo_after_reset", alu_result, 32'h0);
        check("mflo_valid", 32'(valid_out), 1);

        instr(4'd2, 3'd0, 32'h7FFFFFFF, 32'h1);         // ADD overflow wrap
        reg_dst = 1; rd_idx = 5'd9; rt_idx = 5'd4; ctrl_in = 5'h15; pc_next = 32'h100; imm = 32'h4;
        tick();
        check("add_result", alu_result, 32'h80000000);
        check("add_zero", 32'(zero), 0);
        check("add_dest", 32'(dest_reg), 9);
        check("add_ctrl", 32'(ctrl_out), 32'h15);
        check("add_btarget", branch_target, 32'h110);

        instr(4'd6, 3'd0, 32'h1234, 32'h1234);          // SUB equal
        tick();
        check("sub_zero", 32'(zero), 1);
        check("sub_result", alu_result, 0);

        instr(4'd6, 3'd0, 32'd100, 32'd200);            // forwarded SUB
        fwd_a = 2'b10; mem_result = 32'd5; fwd_b = 2'b01; wb_result = 32'd3;
        tick();
        check("fwd_sub", alu_result, 32'd2);
        check("fwd_store", store_data, 32'd3);
        alu_src = 1; imm = 32'd1;
        tick();
        check("fwd_imm_sub", alu_result, 32'd4);
        check("fwd_imm_store", store_data, 32'd3);
        check("fwd_imm_btarget", branch_target, 32'd4);

        instr(4'd2, 3'd0, 32'd10, 32'd4);               // fwd 11 selects register
        fwd_a = 2'b11; mem_result = 32'd99;
        tick();
        check("fwd11_add", alu_result, 32'd14);

        for (int i = 0; i < 5; i++) begin
            instr(lop[i], 3'd0, 32'hF0F01234, 32'h0FF08001);
            tick();
            check($sformatf("logic_op%0d", lop[i]), alu_result, lexp[i]);
        end

        instr(4'd2, 3'd1, 32'hFFFFFFFD, 32'd7);         // MULT -3 x 7, then MFLO
        tick();
        instr(4'd2, 3'd6, 32'h0, 32'h0);
        count_stall(n);
        check("mult_stall_cycles", n, 32);
        tick();
        check("mult_lo", alu_result, 32'hFFFFFFEB);
        instr(4'd2, 3'd5, 32'h0, 32'h0);
        tick();
        check("mult_hi", alu_result, 32'hFFFFFFFF);

        instr(4'd2, 3'd3, 32'hFFFFFFF9, 32'd2);         // DIV -7 / 2
        tick();
        instr(4'd2, 3'd6, 32'h0, 32'h0);
        count_stall(n);
        check("div_stall_cycles", n, DIV_EN ? 32 : 0);
        tick();
        check("div_lo", alu_result, DIV_EN ? 32'hFFFFFFFD : 32'hFFFFFFEB);
        instr(4'd2, 3'd5, 32'h0, 32'h0);
        tick();
        check("div_hi", alu_result, 32'hFFFFFFFF);

        instr(4'd2, 3'd4, 32'd5, 32'd0);                // DIVU 5 / 0
        tick();
        instr(4'd2, 3'd6, 32'h0, 32'h0);
        count_stall(n);
        check("divu0_stall_cycles", n, DIV_EN ? 32 : 0);
        tick();
        check("divu0_lo", alu_result, DIV_EN ? 32'hFFFFFFFF : 32'hFFFFFFEB);
        instr(4'd2, 3'd5, 32'h0, 32'h0);
        tick();
        check("divu0_hi", alu_result, DIV_EN ? 32'd5 : 32'hFFFFFFFF);

        instr(4'd2, 3'd1, 32'd6, 32'd7);                // MULT 6 x 7 with stall_in during BUSY
        tick();
        check("mul2_issue_alu", alu_result, 32'd13);
        check("mul2_issue_valid", 32'(valid_out), 1);
        instr(4'd2, 3'd0, 32'd1, 32'd1);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_alu", alu_result, 32'd13);
        end
        stall_in = 0;
        tick();
        check("stall_release_alu", alu_result, 32'd2);
        instr(4'd2, 3'd7, 32'd1, 32'd2);
        repeat (27) tick();
        check("md7_no_stall", 32'(ex_stall), 0);
        instr(4'd2, 3'd6, 32'h0, 32'h0);
        #1;
        check("done_cycle_stall", 32'(ex_stall), 1);
        tick();
        check("ready_no_stall", 32'(ex_stall), 0);
        tick();
        check("mul2_lo", alu_result, 32'd42);

        instr(4'd2, 3'd0, 32'd1, 32'd2);                // flush
        flush = 1;
        tick();
        check("flush_valid", 32'(valid_out), 0);
        check("flush_alu", alu_result, 32'd3);

        instr(4'd2, 3'd1, 32'hFFFFFFFD, 32'd7);         // reset during BUSY
        tick();
        instr(4'd2, 3'd0, 32'd3, 32'd4);
        repeat (5) tick();
        #2 reset = 0;
        #1;
        check("arst_valid", 32'(valid_out), 0);
        check("arst_alu", alu_result, 0);
        tick();
        reset = 1;
        instr(4'd2, 3'd6, 32'h0, 32'h0);
        #1;
        check("arst_no_stall", 32'(ex_stall), 0);
        tick();
        check("arst_lo", alu_result, 0);
        instr(4'd2, 3'd5, 32'h0, 32'h0);
        tick();
        check("arst_hi", alu_result, 0);
        set_idle();
        repeat (40) tick();
        instr(4'd2, 3'd6, 32'h0, 32'h0);
        tick();
        check("arst_lo_late", alu_result, 0);

        set_idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
